// File: rtl/hex_bank_writer.sv
// hex_bank_writer
// Bank of 7-segment pattern registers written through an address pointer.
// A write fires on the rising edge of wr. The pointer can post-increment
// after each write or be loaded directly. Each display can blink, in which
// case it is blanked during the low blink phase. HEX_flat is fully registered.
module hex_bank_writer #(
  parameter  int NUM_HEX   = 6,
  parameter  int SEG_W     = 7,
  parameter  int BLINK_DIV = 25000000,
  parameter  int AUTO_INC  = 1,
  localparam int ADDR_W    = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1
) (
  input  logic                     CLOCK_50,
  input  logic                     Resetn,
  input  logic                     clr,
  input  logic                     addr_ld,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     wr,
  input  logic [SEG_W-1:0]         seg_in,
  input  logic                     blink_in,
  output logic [NUM_HEX*SEG_W-1:0] HEX_flat,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic [NUM_HEX-1:0]       blink_mask,
  output logic                     err
);

  // Segments are active-low, so all ones turns every segment off.
  localparam logic [SEG_W-1:0]  BLANK   = {SEG_W{1'b1}};
  localparam int                CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(BLINK_DIV - 1);
  localparam logic [ADDR_W:0]   LP_NUM  = NUM_HEX[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_HEX - 1);

  logic [SEG_W-1:0]         r_pattern [NUM_HEX];
  logic [NUM_HEX*SEG_W-1:0] r_hex;
  logic [ADDR_W-1:0]        r_addr;
  logic [NUM_HEX-1:0]       r_mask;
  logic                     r_err;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_phase;
  logic                     r_wr_q;

  logic                     w_wr_evt;
  logic                     w_addr_ok;
  logic                     w_load;
  logic                     w_addr_bad;
  logic                     w_cnt_wrap;
  logic [ADDR_W-1:0]        w_addr_next;

  assign HEX_flat   = r_hex;
  assign cur_addr   = r_addr;
  assign blink_mask = r_mask;
  assign err        = r_err;

  // Decode the write edge, address validity and blink counter wrap.
  // The address check is done one bit wider, so NUM_HEX itself is representable.
  always_comb begin
    w_wr_evt   = wr & ~r_wr_q;
    w_addr_ok  = ({1'b0, addr_in} < LP_NUM);
    w_load     = addr_ld & w_addr_ok;
    w_addr_bad = addr_ld & ~w_addr_ok;
    w_cnt_wrap = (r_cnt == CNT_TOP);
  end

  // Next pointer value: a valid load wins over the post-increment.
  always_comb begin
    w_addr_next = r_addr;
    if (w_load) begin
      w_addr_next = addr_in;
    end else if (w_wr_evt && (AUTO_INC != 0)) begin
      if (r_addr == LP_LAST) begin
        w_addr_next = '0;
      end else begin
        w_addr_next = r_addr + ADDR_W'(1);
      end
    end
  end

  // wr history flop. Reset drives it to 1 so a wr held across reset release
  // does not look like a fresh rising edge.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_wr_q <= 1'b1;
    end else begin
      r_wr_q <= wr;
    end
  end

  // Pattern and blink-mask storage. The write uses the pointer value from
  // before any load or increment in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clr) begin
      for (int i = 0; i < NUM_HEX; i++) begin
        r_pattern[i] <= BLANK;
      end
      r_mask <= '0;
    end else if (w_wr_evt) begin
      for (int i = 0; i < NUM_HEX; i++) begin
        if (r_addr == ADDR_W'(i)) begin
          r_pattern[i] <= seg_in;
          r_mask[i]    <= blink_in;
        end
      end
    end
  end

  // Address pointer register.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clr) begin
      r_addr <= '0;
    end else begin
      r_addr <= w_addr_next;
    end
  end

  // Sticky out-of-range flag. Only clr or reset clears it.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clr) begin
      r_err <= 1'b0;
    end else if (w_addr_bad) begin
      r_err <= 1'b1;
    end
  end

  // Blink timebase: the phase flips each time the counter wraps.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_cnt_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Output register. A blinking display is blanked while the phase is 0.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_hex <= {NUM_HEX{BLANK}};
    end else begin
      for (int i = 0; i < NUM_HEX; i++) begin
        if (r_mask[i] && !r_phase) begin
          r_hex[i*SEG_W +: SEG_W] <= BLANK;
        end else begin
          r_hex[i*SEG_W +: SEG_W] <= r_pattern[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_bank_writer.sv
// tb_hex_bank_writer
// Directed bench for hex_bank_writer (NUM_HEX=6, BLINK_DIV=4, AUTO_INC=1).
module tb_hex_bank_writer;

  localparam int NUM_HEX = 6;
  localparam int SEG_W   = 7;

  logic         CLOCK_50 = 1'b0;
  logic         Resetn;
  logic         clr;
  logic         addr_ld;
  logic [2:0]   addr_in;
  logic         wr;
  logic [6:0]   seg_in;
  logic         blink_in;
  logic [41:0]  HEX_flat;
  logic [2:0]   cur_addr;
  logic [5:0]   blink_mask;
  logic         err;

  int testsRun    = 0;
  int testsFailed = 0;

  hex_bank_writer #(
    .NUM_HEX  (NUM_HEX),
    .SEG_W    (SEG_W),
    .BLINK_DIV(4),
    .AUTO_INC (1)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .clr       (clr),
    .addr_ld   (addr_ld),
    .addr_in   (addr_in),
    .wr        (wr),
    .seg_in    (seg_in),
    .blink_in  (blink_in),
    .HEX_flat  (HEX_flat),
    .cur_addr  (cur_addr),
    .blink_mask(blink_mask),
    .err       (err)
  );

  // 100 MHz style free-running clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Count the comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drive one cycle of inputs, then let one edge happen.
  task automatic applyStimulus(input logic ld, input logic [2:0] ain,
                               input logic w, input logic [6:0] seg,
                               input logic bl, input logic c);
    addr_ld  = ld;
    addr_in  = ain;
    wr       = w;
    seg_in   = seg;
    blink_in = bl;
    clr      = c;
    tick();
  endtask

  function automatic logic [6:0] disp(input int i);
    return HEX_flat[i*SEG_W +: SEG_W];
  endfunction

  initial begin
    logic [6:0] prev;
    logic [6:0] v;
    int         lastChange;
    int         changes;
    int         badRun;
    int         badVal;
    int         steadyBad;

    Resetn = 1'b0;
    clr = 1'b0; addr_ld = 1'b0; addr_in = 3'd0; wr = 1'b0;
    seg_in = 7'h00; blink_in = 1'b0;
    tick();
    tick();

    // Reset state.
    checkOutput("reset_hex",   64'(HEX_flat),   64'h3FF_FFFF_FFFF);
    checkOutput("reset_addr",  64'(cur_addr),   64'd0);
    checkOutput("reset_mask",  64'(blink_mask), 64'd0);
    checkOutput("reset_err",   64'(err),        64'd0);

    Resetn = 1'b1;
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);

    // Single write with two-clock latency.
    applyStimulus(0, 3'd0, 1, 7'h40, 0, 0);
    checkOutput("lat_d0_early", 64'(disp(0)), 64'h7F);
    checkOutput("lat_addr",     64'(cur_addr), 64'd1);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("lat_d0",       64'(disp(0)), 64'h40);
    for (int i = 1; i < NUM_HEX; i++) begin
      checkOutput($sformatf("lat_other%0d", i), 64'(disp(i)), 64'h7F);
    end

    // Six pulses from address 0, pointer wraps.
    applyStimulus(1, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("ld0_addr", 64'(cur_addr), 64'd0);
    for (int k = 0; k < NUM_HEX; k++) begin
      applyStimulus(0, 3'd0, 1, 7'(k), 0, 0);
      applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    end
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    for (int i = 0; i < NUM_HEX; i++) begin
      checkOutput($sformatf("seq_d%0d", i), 64'(disp(i)), 64'(i));
    end
    checkOutput("seq_wrap", 64'(cur_addr), 64'd0);

    // Out-of-range load sets sticky err without moving the pointer.
    applyStimulus(1, 3'd3, 0, 7'h00, 0, 0);
    checkOutput("ld3_addr", 64'(cur_addr), 64'd3);
    applyStimulus(1, 3'd6, 0, 7'h00, 0, 0);
    checkOutput("bad6_err",  64'(err),      64'd1);
    checkOutput("bad6_addr", 64'(cur_addr), 64'd3);
    applyStimulus(1, 3'd7, 0, 7'h00, 0, 0);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("err_sticky", 64'(err),      64'd1);
    checkOutput("bad7_addr",  64'(cur_addr), 64'd3);

    // clr wins over a concurrent write and load.
    applyStimulus(1, 3'd2, 1, 7'h11, 1, 1);
    checkOutput("clr_err",  64'(err),        64'd0);
    checkOutput("clr_addr", 64'(cur_addr),   64'd0);
    checkOutput("clr_mask", 64'(blink_mask), 64'd0);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("clr_hex",  64'(HEX_flat),   64'h3FF_FFFF_FFFF);

    // Blinking display 2, steady display 3.
    applyStimulus(1, 3'd2, 0, 7'h00, 0, 0);
    applyStimulus(0, 3'd0, 1, 7'h12, 1, 0);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    applyStimulus(0, 3'd0, 1, 7'h34, 0, 0);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("blink_mask", 64'(blink_mask), 64'b000100);
    checkOutput("blink_addr", 64'(cur_addr),   64'd4);
    prev = disp(2);
    lastChange = -1;
    changes = 0; badRun = 0; badVal = 0; steadyBad = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      v = disp(2);
      if (v !== 7'h12 && v !== 7'h7F) badVal++;
      if (disp(3) !== 7'h34) steadyBad++;
      if (disp(0) !== 7'h7F) steadyBad++;
      if (v !== prev) begin
        if (lastChange >= 0 && (c - lastChange) != 4) badRun++;
        lastChange = c;
        changes++;
      end
      prev = v;
    end
    checkOutput("blink_values",  64'(badVal),       64'd0);
    checkOutput("blink_period",  64'(badRun),       64'd0);
    checkOutput("blink_toggles", 64'(changes >= 5), 64'd1);
    checkOutput("blink_steady",  64'(steadyBad),    64'd0);

    // Write and load in the same clock.
    applyStimulus(1, 3'd1, 0, 7'h00, 0, 0);
    applyStimulus(1, 3'd4, 1, 7'h55, 0, 0);
    checkOutput("both_addr", 64'(cur_addr), 64'd4);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("both_d1",   64'(disp(1)),  64'h55);
    checkOutput("both_d4",   64'(disp(4)),  64'h7F);

    // wr held high through reset and its release must not write.
    Resetn = 1'b0;
    applyStimulus(0, 3'd0, 1, 7'h01, 0, 0);
    applyStimulus(0, 3'd0, 1, 7'h01, 0, 0);
    Resetn = 1'b1;
    applyStimulus(0, 3'd0, 1, 7'h01, 0, 0);
    applyStimulus(0, 3'd0, 1, 7'h01, 0, 0);
    applyStimulus(0, 3'd0, 1, 7'h01, 0, 0);
    checkOutput("hold_hex",  64'(HEX_flat), 64'h3FF_FFFF_FFFF);
    checkOutput("hold_addr", 64'(cur_addr), 64'd0);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    applyStimulus(0, 3'd0, 1, 7'h0A, 0, 0);
    applyStimulus(0, 3'd0, 0, 7'h00, 0, 0);
    checkOutput("rewr_d0",   64'(disp(0)),  64'h0A);
    checkOutput("rewr_addr", 64'(cur_addr), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
